wb_line_responder: RTL and testbench
====================================

# wb_line_responder

Wishbone slave that answers the 128-bit line requests issued by the `ifetch` and `memory` master ports of the `mp3` core. It holds a local line-organised memory array and responds with a programmable fixed latency. It honours byte-lane selects on writes and returns whole lines on reads. One instance sits behind each master port in the system testbench and in the FPGA top; the physical-memory model it replaces is retired.

## Interface
Parameters:
- `LATENCY`, 4, cycles from request acceptance to `ACK`; legal range 1..15.
- `DEPTH_LOG2`, 8, log2 of line count. Line index = `ADR[DEPTH_LOG2-1:0]`; higher `ADR` bits are ignored, so addresses alias.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `CYC`  in  1  bus cycle valid.
- `STB`  in  1  strobe; a request exists when `CYC & STB`.
- `WE`  in  1  1 = write, 0 = read.
- `ADR`  in  12  line address (byte address [15:4]).
- `SEL`  in  16  byte enables; bit i covers bits [8i+7:8i].
- `DAT_M`  in  128  write data.
- `DAT_S`  out  128  read data; valid only while `ACK`=1.
- `ACK`  out  1  one-cycle response strobe.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: when `CYC & STB` is sampled, capture `ADR`, `WE`, `SEL` and `DAT_M`, and load the down-counter with `LATENCY-1`.
  - `LATENCY`=1: go straight to RESP.
  - Otherwise: go to BUSY.
- BUSY: decrement the counter each cycle. Enter RESP on the edge where the counter is 1.
- RESP: `ACK`=1 for exactly one cycle, then return to IDLE.
- Read: `DAT_S` is the full stored line at the captured index, registered on the edge that enters RESP. `SEL` is ignored.
- Write: on the edge that ends RESP, each byte i with captured `SEL[i]`=1 takes `DAT_M` byte i. Other bytes are unchanged. `DAT_S`=0.
- `SEL`=16'h0000 on a write: still acknowledged, memory unchanged.
- Abort: if `CYC` is sampled 0 in BUSY, return to IDLE. No `ACK` is issued and no write occurs. `CYC` is not checked in RESP; the transaction completes.
- Input changes after acceptance are ignored; only captured values are used.
- A request still asserted in the IDLE cycle after RESP is treated as a new transaction.
  - Duplicate reads are harmless.
  - Duplicate writes are idempotent.
  - Masters must drop `STB` in the cycle after `ACK`.
- `DAT_S`=0 whenever `ACK`=0.

## Timing
- Reset (async assert, sync deassert by the integrator):
  - State = IDLE, counter = 0, `ACK`=0, `DAT_S`=0, captured registers = 0.
  - Memory array is not reset; simulation initialises it to all zeros.
- Reset asserted mid-transaction: `ACK` and `DAT_S` drop immediately and asynchronously, and any pending write is discarded.
- Latency: request first sampled in cycle 0 gives `ACK`=1 in cycle `LATENCY`, i.e. `LATENCY` cycles after acceptance.
- Throughput: back-to-back requests complete at most one per `LATENCY+1` cycles, because of the one IDLE cycle.
- Read-after-write to the same line: a write committed at the end of RESP is visible to a read accepted in the following IDLE cycle.
- No combinational path from any input to `ACK` or `DAT_S`. Both outputs are registered.

## Test plan
- **Read after reset.** After reset, read `ADR`=12'h010 with `LATENCY`=4 -> `ACK` high only in cycle 4, `DAT_S`=128'h0, `ACK` low in cycle 5.
- **Full and partial write.**
  - Write `ADR`=12'h010, `SEL`=16'hFFFF, `DAT_M`=128'h00112233_44556677_8899AABB_CCDDEEFF, then read it -> `DAT_S` equals the written value.
  - Then write `SEL`=16'h0001, `DAT_M`=all 5A, then read -> `DAT_S`=128'h00112233_44556677_8899AABB_CCDDEE5A.
- **Aliasing with `DEPTH_LOG2`=8.** Write `ADR`=12'h105 (full line, 128'h1), then read `ADR`=12'h005 -> `DAT_S`=128'h1.
- **Abort.** Write request accepted; `CYC` dropped in cycle 2 with `LATENCY`=4 -> no `ACK` ever, and a subsequent read shows the old line content.
- **Latency extremes.**
  - `LATENCY`=1, back-to-back reads with `STB` held after `ACK` -> `ACK` in cycles 1, 3, 5; never in two consecutive cycles.
  - `LATENCY`=15 -> first `ACK` in cycle 15.
- **Reset mid-transaction.** `rst_n` pulsed low in cycle 2 of a `SEL`=16'hFFFF write -> `ACK`=0 immediately, state IDLE, memory unchanged; the next read returns prior data with normal latency.

Source files
------------

// File: rtl/wb_line_responder.sv
// Wishbone line slave: local line memory answering 128-bit read/write requests
// with a fixed programmable latency and byte-lane write enables.
module wb_line_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         CYC,
  input  logic         STB,
  input  logic         WE,
  input  logic [11:0]  ADR,
  input  logic [15:0]  SEL,
  input  logic [127:0] DAT_M,
  output logic [127:0] DAT_S,
  output logic         ACK
);

  localparam int unsigned AW    = 12;
  localparam int unsigned LW    = 128;
  localparam int unsigned BW    = LW / 8;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          we_q, we_d;
  logic [BW-1:0] sel_q, sel_d;
  logic [LW-1:0] dat_q, dat_d;
  logic          ack_q, ack_d;
  logic [LW-1:0] dat_s_q, dat_s_d;
  logic          mem_we_c;

  logic [LW-1:0] mem [DEPTH];

  // Upper address bits are captured but deliberately unused: addresses alias.
  logic unused_adr_c;
  assign unused_adr_c = ^adr_q;

  // State and captured-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      dat_s_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      dat_s_q <= dat_s_d;
    end
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    dat_d    = dat_q;
    ack_d    = 1'b0;
    dat_s_d  = '0;
    mem_we_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (CYC && STB) begin
          adr_d = ADR;
          we_d  = WE;
          sel_d = SEL;
          dat_d = DAT_M;
          cnt_d = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            // Single-cycle latency: read data comes from the address being captured.
            state_d = RESP;
            ack_d   = 1'b1;
            if (!WE) dat_s_d = mem[ADR[DEPTH_LOG2-1:0]];
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!CYC) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
          ack_d   = 1'b1;
          if (!we_q) dat_s_d = mem[adr_q[DEPTH_LOG2-1:0]];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d  = IDLE;
        mem_we_c = we_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte-masked write commit on the edge that leaves RESP.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(BW); b++) begin
        if (sel_q[b]) mem[adr_q[DEPTH_LOG2-1:0]][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

  assign ACK   = ack_q;
  assign DAT_S = dat_s_q;

endmodule

// File: tb/tb_wb_line_responder.sv
// Directed bench for wb_line_responder: three instances at latencies 4, 1 and 15,
// each with its own CYC/STB so memories only see their own traffic.
module tb_wb_line_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   cyc = '0;
  logic [2:0]   stb = '0;
  logic         we = 1'b0;
  logic [11:0]  adr = '0;
  logic [15:0]  sel = '0;
  logic [127:0] dat_m = '0;
  logic [2:0]   ack;
  logic [127:0] dat_s [3];

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] LINE_A  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] LINE_A2 = 128'h00112233_44556677_8899AABB_CCDDEE5A;
  localparam logic [127:0] ALL_5A  = {16{8'h5A}};

  always #5 clk = ~clk;

  wb_line_responder #(.LATENCY(4), .DEPTH_LOG2(8)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .CYC(cyc[0]), .STB(stb[0]), .WE(we), .ADR(adr),
    .SEL(sel), .DAT_M(dat_m), .DAT_S(dat_s[0]), .ACK(ack[0]));

  wb_line_responder #(.LATENCY(1), .DEPTH_LOG2(8)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .CYC(cyc[1]), .STB(stb[1]), .WE(we), .ADR(adr),
    .SEL(sel), .DAT_M(dat_m), .DAT_S(dat_s[1]), .ACK(ack[1]));

  wb_line_responder #(.LATENCY(15), .DEPTH_LOG2(8)) u_lat15 (
    .clk(clk), .rst_n(rst_n), .CYC(cyc[2]), .STB(stb[2]), .WE(we), .ADR(adr),
    .SEL(sel), .DAT_M(dat_m), .DAT_S(dat_s[2]), .ACK(ack[2]));

  // One transaction on instance k; cycle 0 is the cycle the request is first sampled.
  // Inputs are scrambled after acceptance to show only captured values matter.
  task automatic run_txn(input int k, input logic w, input logic [11:0] a,
                         input logic [15:0] s, input logic [127:0] d, input int abort_at,
                         output int ack_cyc, output int n_ack, output logic [127:0] rdata);
    @(negedge clk);
    cyc = '0; stb = '0;
    cyc[k] = 1'b1; stb[k] = 1'b1;
    we = w; adr = a; sel = s; dat_m = d;
    ack_cyc = -1; n_ack = 0; rdata = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ack[k]) begin
        n_ack++;
        if (ack_cyc < 0) begin
          ack_cyc = c;
          rdata = dat_s[k];
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
      end else begin
        checks++;
        if (dat_s[k] !== '0) begin
          errors++;
          $display("FAIL dat_s_idle inst%0d cycle %0d: got %h want 0", k, c, dat_s[k]);
        end
      end
      if (c == abort_at) begin
        cyc[k] = 1'b0; stb[k] = 1'b0;
      end
      if (c == 1) begin
        we = ~w; adr = ~a; sel = ~s; dat_m = ~d;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ack[k] !== 1'b0 || dat_s[k] !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: got ack=%b dat=%h want ack=0 dat=0", k, ack[k], dat_s[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_after_reset();
    int ac, na; logic [127:0] rd;
    run_txn(0, 1'b0, 12'h010, 16'hFFFF, '0, 0, ac, na, rd);
    checks++;
    if (ac !== 4 || na !== 1) begin
      errors++;
      $display("FAIL read_reset_latency: got ack_cycle=%0d acks=%0d want 4 and 1", ac, na);
    end
    checks++;
    if (rd !== '0) begin
      errors++;
      $display("FAIL read_reset_data: got %h want 0", rd);
    end
  endtask

  task automatic test_write_partial();
    int ac, na; logic [127:0] rd;
    run_txn(0, 1'b1, 12'h010, 16'hFFFF, LINE_A, 0, ac, na, rd);
    checks++;
    if (ac !== 4 || na !== 1 || rd !== '0) begin
      errors++;
      $display("FAIL write_full_ack: got cycle=%0d acks=%0d dat=%h want 4, 1, 0", ac, na, rd);
    end
    run_txn(0, 1'b0, 12'h010, 16'h0000, '0, 0, ac, na, rd);
    checks++;
    if (rd !== LINE_A) begin
      errors++;
      $display("FAIL write_full_read: got %h want %h", rd, LINE_A);
    end
    run_txn(0, 1'b1, 12'h010, 16'h0001, ALL_5A, 0, ac, na, rd);
    run_txn(0, 1'b0, 12'h010, 16'h0000, '0, 0, ac, na, rd);
    checks++;
    if (rd !== LINE_A2) begin
      errors++;
      $display("FAIL write_partial_read: got %h want %h", rd, LINE_A2);
    end
    run_txn(0, 1'b1, 12'h010, 16'h0000, {128{1'b1}}, 0, ac, na, rd);
    checks++;
    if (ac !== 4 || na !== 1) begin
      errors++;
      $display("FAIL write_sel0_ack: got cycle=%0d acks=%0d want 4 and 1", ac, na);
    end
    run_txn(0, 1'b0, 12'h010, 16'hFFFF, '0, 0, ac, na, rd);
    checks++;
    if (rd !== LINE_A2) begin
      errors++;
      $display("FAIL write_sel0_read: got %h want %h", rd, LINE_A2);
    end
  endtask

  task automatic test_alias();
    int ac, na; logic [127:0] rd;
    run_txn(0, 1'b1, 12'h105, 16'hFFFF, 128'h1, 0, ac, na, rd);
    run_txn(0, 1'b0, 12'h005, 16'h0000, '0, 0, ac, na, rd);
    checks++;
    if (rd !== 128'h1) begin
      errors++;
      $display("FAIL alias_read: got %h want 1", rd);
    end
    run_txn(0, 1'b0, 12'hF10, 16'h0000, '0, 0, ac, na, rd);
    checks++;
    if (rd !== LINE_A2) begin
      errors++;
      $display("FAIL alias_other_line: got %h want %h", rd, LINE_A2);
    end
  endtask

  task automatic test_abort();
    int ac, na; logic [127:0] rd;
    run_txn(0, 1'b1, 12'h010, 16'hFFFF, {16{8'hA5}}, 2, ac, na, rd);
    checks++;
    if (na !== 0) begin
      errors++;
      $display("FAIL abort_no_ack: got acks=%0d want 0", na);
    end
    run_txn(0, 1'b0, 12'h010, 16'h0000, '0, 0, ac, na, rd);
    checks++;
    if (rd !== LINE_A2 || ac !== 4) begin
      errors++;
      $display("FAIL abort_read: got %h cycle=%0d want %h cycle=4", rd, ac, LINE_A2);
    end
  endtask

  // LATENCY=1, write then read held without a gap: ACK on odd cycles, RAW visible.
  task automatic test_back_to_back();
    logic [127:0] d;
    d = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    @(negedge clk);
    cyc = '0; stb = '0;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    we = 1'b1; adr = 12'h030; sel = 16'hFFFF; dat_m = d;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (ack[1] !== logic'(c % 2)) begin
        errors++;
        $display("FAIL b2b_ack cycle %0d: got %b want %b", c, ack[1], logic'(c % 2));
      end
      if (c == 3 || c == 5) begin
        checks++;
        if (dat_s[1] !== d) begin
          errors++;
          $display("FAIL b2b_raw_data cycle %0d: got %h want %h", c, dat_s[1], d);
        end
      end
      if (c == 1) begin
        we = 1'b0; dat_m = '0;
      end
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency15();
    int ac, na; logic [127:0] rd;
    run_txn(2, 1'b0, 12'h000, 16'hFFFF, '0, 0, ac, na, rd);
    checks++;
    if (ac !== 15 || na !== 1 || rd !== '0) begin
      errors++;
      $display("FAIL lat15: got cycle=%0d acks=%0d dat=%h want 15, 1, 0", ac, na, rd);
    end
  endtask

  task automatic test_reset_mid();
    int ac, na; logic [127:0] rd;
    // Reset in BUSY of a full write: write discarded.
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1;
    we = 1'b1; adr = 12'h010; sel = 16'hFFFF; dat_m = {16{8'h77}};
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_ack: got %b want 0", ack[0]);
    end
    @(negedge clk);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    rst_n = 1'b1;
    run_txn(0, 1'b0, 12'h010, 16'h0000, '0, 0, ac, na, rd);
    checks++;
    if (rd !== LINE_A2 || ac !== 4 || na !== 1) begin
      errors++;
      $display("FAIL rst_busy_read: got %h cycle=%0d acks=%0d want %h, 4, 1", rd, ac, na, LINE_A2);
    end
    // Reset during RESP of a read: ACK and DAT_S drop asynchronously.
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1;
    we = 1'b0; adr = 12'h010;
    repeat (4) @(negedge clk);
    checks++;
    if (ack[0] !== 1'b1 || dat_s[0] !== LINE_A2) begin
      errors++;
      $display("FAIL rst_resp_pre: got ack=%b dat=%h want 1 and %h", ack[0], dat_s[0], LINE_A2);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack[0] !== 1'b0 || dat_s[0] !== '0) begin
      errors++;
      $display("FAIL rst_resp_drop: got ack=%b dat=%h want 0 and 0", ack[0], dat_s[0]);
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_partial();
    test_alias();
    test_abort();
    test_back_to_back();
    test_latency15();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
